// File: rtl/mux_4x1_arbiter_pkg.sv
// Shared arbiter definitions: state encodings, requester count and index width.
package mux_4x1_arbiter_pkg;

    localparam int unsigned ARB_N     = 4;
    localparam int unsigned ARB_IDX_W = 2;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mux_4x1.sv
// Four-input select cell; the output is the complement of the selected input.
module mux_4x1 (
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic s0,
    input  logic s1,
    output logic y
);

    logic [3:0] din;

    assign din = {d3, d2, d1, d0};
    assign y   = ~din[{s1, s0}];

endmodule

// File: rtl/mux_4x1_arbiter.sv
// Round-robin arbiter with bounded hold that owns one mux_4x1 and delivers the
// granted requester's data bit in true polarity.
module mux_4x1_arbiter
    import mux_4x1_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ARB_N-1:0] req,
    input  logic [ARB_N-1:0] d,
    output logic [ARB_N-1:0] gnt,
    output logic             s0,
    output logic             s1,
    output logic             busy,
    output logic             dout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_e           state_q, state_d;
    logic [ARB_IDX_W-1:0] owner_q, owner_d;
    logic [ARB_IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]     hold_q, hold_d;
    logic [ARB_N-1:0]     gnt_q, gnt_d;
    logic [ARB_IDX_W-1:0] sel_q, sel_d;
    logic                 busy_q, busy_d;
    logic [ARB_IDX_W-1:0] idle_pick, rel_ptr, rel_pick;
    logic                 mux_y;

    // First requester at or after p, wrapping 3 -> 0.
    function automatic logic [ARB_IDX_W-1:0] rr_pick(input logic [ARB_N-1:0] r,
                                                     input logic [ARB_IDX_W-1:0] p);
        logic                 found;
        logic [ARB_IDX_W-1:0] idx;
        logic [ARB_IDX_W-1:0] win;
        found = 1'b0;
        win   = p;
        for (int unsigned i = 0; i < ARB_N; i++) begin
            idx = p + ARB_IDX_W'(i);
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign idle_pick = rr_pick(req, ptr_q);
    assign rel_ptr   = owner_q + ARB_IDX_W'(1);
    assign rel_pick  = rr_pick(req, rel_ptr);

    // Next-state: grant from idle, extend, or release and re-arbitrate in one edge.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    state_d = ARB_GRANT;
                    owner_d = idle_pick;
                    gnt_d   = ARB_N'(1) << idle_pick;
                    sel_d   = idle_pick;
                    hold_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            ARB_GRANT: begin
                if (req[owner_q] && (hold_q < HOLD_LAST)) begin
                    hold_d = hold_q + CNT_W'(1);
                end else begin
                    ptr_d = rel_ptr;
                    if (|req) begin
                        owner_d = rel_pick;
                        gnt_d   = ARB_N'(1) << rel_pick;
                        sel_d   = rel_pick;
                        hold_d  = '0;
                    end else begin
                        // Selects keep the last owner so the mux does not toggle while idle.
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    mux_4x1 u_mux (
        .d0 (d[0]),
        .d1 (d[1]),
        .d2 (d[2]),
        .d3 (d[3]),
        .s0 (sel_q[0]),
        .s1 (sel_q[1]),
        .y  (mux_y)
    );

    // The cell inverts, so re-invert and gate with busy.
    assign dout = busy_q & ~mux_y;
    assign gnt  = gnt_q;
    assign s0   = sel_q[0];
    assign s1   = sel_q[1];
    assign busy = busy_q;

endmodule

// File: tb/tb_mux_4x1_arbiter.sv
// Scoreboard bench: directed scenarios plus random traffic against a cycle-level
// round-robin model; a monitor compares DUT outputs each cycle.
module tb_mux_4x1_arbiter;

    localparam int unsigned MAX_HOLD = 4;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       dout;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic       s0, s1, busy, dout;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   stim_done = 1'b0;

    // Reference model state
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_len   = 0;
    int m_sel   = 0;

    mux_4x1_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .d     (d),
        .gnt   (gnt),
        .s0    (s0),
        .s1    (s1),
        .busy  (busy),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, want, $time);
    endtask

    // Grant the first requester at or after m_ptr, or go idle.
    task automatic model_arbitrate(input logic [3:0] r);
        if (r == 4'b0) begin
            m_busy = 1'b0;
        end else begin
            for (int k = 3; k >= 0; k--)
                if (r[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
            m_busy = 1'b1;
            m_len  = 1;
            m_sel  = m_owner;
        end
    endtask

    task automatic model_edge(input logic [3:0] r, input logic rn);
        if (!rn) begin
            m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_len = 0; m_sel = 0;
        end else if (m_busy) begin
            if (r[m_owner] && m_len < int'(MAX_HOLD)) begin
                m_len++;
            end else begin
                m_ptr = (m_owner + 1) % 4;
                model_arbitrate(r);
            end
        end else begin
            model_arbitrate(r);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] dv, input logic rn);
        exp_t e;
        @(negedge clk);
        req = r; d = dv; rst_n = rn;
        model_edge(r, rn);
        e.gnt  = m_busy ? (4'b0001 << m_owner) : 4'b0000;
        e.sel  = 2'(m_sel);
        e.busy = m_busy;
        e.dout = m_busy & dv[m_owner];
        exp_q.push_back(e);
    endtask

    task automatic run(input logic [3:0] r, input int cycles);
        for (int i = 0; i < cycles; i++) drive(r, 4'($urandom_range(0, 15)), 1'b1);
    endtask

    // Monitor: one expected entry per clock edge after stimulus begins.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gnt",  gnt,           e.gnt);
                check("sel",  {2'b00, s1, s0}, {2'b00, e.sel});
                check("busy", {3'b0, busy},  {3'b0, e.busy});
                check("dout", {3'b0, dout},  {3'b0, e.dout});
            end
        end
    end

    initial begin
        logic [3:0] r;
        req = 4'b0; d = 4'b0; rst_n = 1'b0;
        // Fair rotation
        drive(4'b0000, 4'b0000, 1'b0);
        run(4'b1111, 20);
        // Sole requester, self re-grant with no gap
        drive(4'b0000, 4'b0000, 1'b0);
        run(4'b0100, 20);
        // Early release then idle with selects retained
        drive(4'b0000, 4'b0000, 1'b0);
        run(4'b0101, 2);
        run(4'b0100, 3);
        run(4'b0000, 3);
        // Pointer wrap from owner 3
        drive(4'b0000, 4'b0000, 1'b0);
        run(4'b1000, 1);
        run(4'b1001, 6);
        // Data polarity on owner 2 and while idle
        drive(4'b0000, 4'b0000, 1'b0);
        drive(4'b0100, 4'b0100, 1'b1);
        drive(4'b0100, 4'b1011, 1'b1);
        drive(4'b0100, 4'b0100, 1'b1);
        drive(4'b0000, 4'b1111, 1'b1);
        drive(4'b0000, 4'b1111, 1'b1);
        // Reset mid-grant: owner 2, fourth cycle of its grant
        drive(4'b0000, 4'b0000, 1'b0);
        run(4'b1111, 12);
        drive(4'b1111, 4'b1111, 1'b0);
        run(4'b1111, 3);
        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
            drive(r, 4'($urandom_range(0, 15)), ($urandom_range(0, 60) != 0));
        end
        @(negedge clk);
        @(negedge clk);
        check("queue_drain", 4'(exp_q.size()), 4'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
